// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared types and constants for the pipeline hazard/stall controller
package hazard_stall_ctrl_pkg;

    // RUN: normal issue; MEM_WAIT: pipeline frozen on an outstanding data-memory access
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam logic [4:0] REG_X0       = 5'd0;
    localparam int         XLEN_DEFAULT = 64;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - hazard inputs and pipeline/PC control outputs of the stall controller
interface hazard_stall_ctrl_if
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic            idex_mem_read;
    logic [4:0]      idex_rd;
    logic            ex_branch_taken;
    logic [XLEN-1:0] ex_branch_target;
    logic            mem_req;
    logic            dmem_ready;

    logic            pc_write;
    logic            pc_redirect;
    logic [XLEN-1:0] pc_target;
    logic            ifid_write;
    logic            ifid_flush;
    logic            idex_write;
    logic            idex_bubble;
    logic            exmem_write;

    // Pipeline side: supplies hazard information, consumes control
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, idex_mem_read, idex_rd,
               ex_branch_taken, ex_branch_target, mem_req, dmem_ready,
        input  pc_write, pc_redirect, pc_target, ifid_write, ifid_flush,
               idex_write, idex_bubble, exmem_write
    );

    // Controller side
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, idex_mem_read, idex_rd,
               ex_branch_taken, ex_branch_target, mem_req, dmem_ready,
        output pc_write, pc_redirect, pc_target, ifid_write, ifid_flush,
               idex_write, idex_bubble, exmem_write
    );
endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// rtl/hazard_stall_ctrl_sat_counter.sv - event counter that sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Increment on request unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - priority hazard resolution (mem freeze > redirect > load-use) for the 5-stage core
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    hazard_stall_ctrl_if.slave bus,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);
    localparam int                WAIT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;

    logic rs1_hit;
    logic rs2_hit;
    logic freeze;
    logic redirect;
    logic load_use;

    // Classify the current cycle; each class masks the lower-priority ones
    always_comb begin
        rs1_hit  = bus.id_use_rs1 && (bus.id_rs1 == bus.idex_rd);
        rs2_hit  = bus.id_use_rs2 && (bus.id_rs2 == bus.idex_rd);
        freeze   = (state_q == MEM_WAIT) ? !bus.dmem_ready
                                         : (bus.mem_req && !bus.dmem_ready);
        redirect = !freeze && bus.ex_branch_taken;
        // A squashed ID instruction cannot need a stall, and x0 is never a real dependency
        load_use = !freeze && !redirect && bus.idex_mem_read &&
                   (bus.idex_rd != REG_X0) && (rs1_hit || rs2_hit);
    end

    // Drive stage enables/flushes and the PC unit; reset forces a free-running pipeline
    always_comb begin
        bus.pc_write    = 1'b1;
        bus.pc_redirect = 1'b0;
        bus.ifid_write  = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_write  = 1'b1;
        bus.idex_bubble = 1'b0;
        bus.exmem_write = 1'b1;
        bus.pc_target   = reset ? {XLEN{1'b0}} : bus.ex_branch_target;
        if (!reset) begin
            if (freeze) begin
                bus.pc_write    = 1'b0;
                bus.ifid_write  = 1'b0;
                bus.idex_write  = 1'b0;
                bus.exmem_write = 1'b0;
            end else if (redirect) begin
                bus.pc_redirect = 1'b1;
                bus.ifid_flush  = 1'b1;
                bus.idex_bubble = 1'b1;
            end else if (load_use) begin
                bus.pc_write    = 1'b0;
                bus.ifid_write  = 1'b0;
                bus.idex_bubble = 1'b1;
            end
        end
    end

    // Next state: stay in MEM_WAIT while frozen, count wait cycles, latch timeout
    always_comb begin
        state_d       = RUN;
        wait_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q;
        if (freeze) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
            if (wait_cnt_d == WAIT_MAX) begin
                mem_timeout_d = 1'b1;
            end
        end
    end

    // State, wait counter and sticky timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (freeze || load_use),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redirect),
        .count (flush_count)
    );
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline control sequencer for the 5-stage RV64 core. It drives the PC unit (PCWrite, BranchTaken, BranchTarget) and the IF/ID, ID/EX and EX/MEM register enables and flushes. It resolves three hazard classes by priority: data-memory wait, taken branch, load-use. It also keeps saturating stall/flush statistics and a sticky memory-timeout flag.

Parameters:
XLEN, 64, PC/target width
CNT_W, 16, width of statistics counters
TIMEOUT, 255, MEM_WAIT cycles before mem_timeout sets

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
id_rs1  in  5  ID-stage source register 1
id_rs2  in  5  ID-stage source register 2
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
idex_mem_read  in  1  instruction in EX is a load
idex_rd  in  5  destination register of instruction in EX
ex_branch_taken  in  1  branch/jump in EX resolved taken
ex_branch_target  in  XLEN  resolved target
mem_req  in  1  MEM-stage instruction accesses data memory
dmem_ready  in  1  data memory completes access this cycle
pc_write  out  1  to PC unit PCWrite
pc_redirect  out  1  to PC unit BranchTaken
pc_target  out  XLEN  to PC unit BranchTarget
ifid_write  out  1  IF/ID enable
ifid_flush  out  1  IF/ID flush to NOP
idex_write  out  1  ID/EX enable
idex_bubble  out  1  ID/EX load NOP
exmem_write  out  1  EX/MEM enable
stall_cycles  out  CNT_W  saturating count of frozen/stalled cycles
flush_count  out  CNT_W  saturating count of redirects
mem_timeout  out  1  sticky; set when wait_cnt reaches TIMEOUT

Behaviour:
- Reset is asynchronous, active-high; clock is clk. Reset sets state=RUN, wait_cnt=0, stall_cycles=0, flush_count=0, mem_timeout=0.
- While reset is high, outputs are forced: all *_write=1, pc_redirect=0, ifid_flush=0, idex_bubble=0, pc_target=0.
- Control outputs are combinational from registered state and current inputs: zero latency within the cycle.
- States: RUN, MEM_WAIT.
- Default (no hazard): all *_write=1, flush/bubble/redirect=0.
- pc_target always equals ex_branch_target when not in reset. It is qualified by pc_redirect.
- Priority 1, memory freeze. Applies in RUN when mem_req=1 and dmem_ready=0, or in MEM_WAIT when dmem_ready=0.
  - All *_write=0, pc_redirect=0, no flush/bubble.
  - RUN goes to MEM_WAIT. wait_cnt increments, saturating at TIMEOUT.
  - When wait_cnt==TIMEOUT, mem_timeout sets. Only reset clears it.
- MEM_WAIT with dmem_ready=1: return to RUN and clear wait_cnt. That same cycle is evaluated by priorities 2/3/default, so the stage registers advance.
- Priority 2, redirect (ex_branch_taken=1, no freeze):
  - pc_redirect=1, pc_write=1, ifid_flush=1, idex_bubble=1. ifid_write and exmem_write stay 1.
  - Load-use is ignored because the ID instruction is squashed.
  - A branch held in EX during a freeze redirects on the release cycle.
- Priority 3, load-use. Condition: idex_mem_read=1, idex_rd!=0, and (id_use_rs1 && id_rs1==idex_rd) or (id_use_rs2 && id_rs2==idex_rd).
  - pc_write=0, ifid_write=0, idex_bubble=1, idex_write=1, exmem_write=1. The stall lasts exactly one cycle.
- stall_cycles increments on every freeze or load-use cycle. flush_count increments on every redirect cycle. Both saturate at all-ones.
- x0 never causes a load-use stall.
- Reset asserted mid-MEM_WAIT returns to RUN immediately, with counters cleared.

Decomposition:
- Shared package holds the state enum (RUN, MEM_WAIT), REG_X0=5'd0, and the XLEN default.
- One natural sub-module: sat_counter (parameterised width, inc input, saturates at all-ones). Instantiate it twice, once per statistic.

Test Plan:
- Load-use: idex_mem_read=1, idex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_cycles 0->1. Repeat with idex_rd=0 -> no stall.
- Branch: ex_branch_taken=1, target=64'h100 -> pc_redirect=1, pc_target=64'h100, ifid_flush=1, idex_bubble=1; PC unit holds 64'h100 next edge; flush_count=1.
- Branch plus load-use in the same cycle -> redirect wins: pc_write=1, no load-use stall; stall_cycles unchanged.
- Memory wait: mem_req=1, dmem_ready=0 for 3 cycles, then 1 -> 3 cycles of all *_write=0, then advance; stall_cycles=3; state back to RUN.
- Branch held during freeze: ex_branch_taken=1 throughout a 2-cycle wait -> pc_redirect=0 while frozen, =1 on the release cycle.
- Timeout/reset: TIMEOUT=4, dmem_ready held 0 -> mem_timeout=1 after 4 wait cycles and stays set. Async reset mid-wait -> outputs forced immediately; mem_timeout, counters and state cleared.
